// File: rtl/input_interface.sv
// input_interface: deserialises an 8-bit byte stream into 128-bit key
// and plaintext blocks, and hands each plaintext to the round transformer.
// Ports:
//   clk, rst_          clock, synchronous active-low reset
//   data_in/data_valid byte stream input; key_sel marks a key frame
//   engine_ready       transformer can take a block
//   in_ready           byte port accepting (low while a block is parked)
//   plaintext, key     delivered blocks, first byte in [127:120]
//   key_valid          a key has been loaded since reset
//   start, frame_err   one-cycle pulses
module input_interface #(
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst_,
   input  logic [7:0]   data_in,
   input  logic         data_valid,
   input  logic         key_sel,
   input  logic         engine_ready,
   output logic         in_ready,
   output logic [127:0] plaintext,
   output logic [127:0] key,
   output logic         key_valid,
   output logic         start,
   output logic         frame_err
);

   localparam int IW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int LIMI = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [IW-1:0] LIM = IW'(LIMI);

   typedef enum logic {
      S_COLLECT = 1'b0,
      S_WAIT    = 1'b1
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [3:0]     r_byte_cnt;
   logic [IW-1:0]  r_idle_cnt;
   logic [119:0]   r_shift;
   logic           r_type;
   logic [127:0]   r_pend;
   logic           r_pend_key;
   logic [127:0]   r_pt;
   logic [127:0]   r_key;
   logic           r_key_valid;
   logic           r_start;
   logic           r_frame_err;

   logic           w_accept;
   logic           w_last;
   logic           w_type;
   logic [127:0]   w_value;
   logic           w_idle_run;
   logic           w_timeout;
   logic           w_commit;
   logic [127:0]   w_commit_val;
   logic           w_commit_key;
   logic           w_drop;
   logic           w_park;

   assign w_accept = data_valid && (r_state == S_COLLECT);
   assign w_last   = w_accept && (r_byte_cnt == 4'd15);
   // Frame type comes from key_sel on the first byte only.
   assign w_type   = (r_byte_cnt == 4'd0) ? key_sel : r_type;
   assign w_value  = {r_shift, data_in};

   // Idle counting only inside a partial frame; a byte on the
   // limit edge wins over the timeout.
   assign w_idle_run = (TIMEOUT > 0) && (r_state == S_COLLECT) &&
                       (r_byte_cnt != 4'd0) && !w_accept;
   assign w_timeout  = w_idle_run && (r_idle_cnt == LIM);

   always_comb begin
      w_state_nxt  = r_state;
      w_commit     = 1'b0;
      w_commit_val = w_value;
      w_commit_key = w_type;
      w_drop       = 1'b0;
      w_park       = 1'b0;
      case (r_state)
         S_COLLECT: begin
            if (w_last) begin
               if (!w_type && !r_key_valid) begin
                  w_drop = 1'b1;
               end else if (engine_ready) begin
                  w_commit = 1'b1;
               end else begin
                  w_park      = 1'b1;
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (engine_ready) begin
               w_commit     = 1'b1;
               w_commit_val = r_pend;
               w_commit_key = r_pend_key;
               w_state_nxt  = S_COLLECT;
            end
         end
         default: w_state_nxt = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         r_state     <= S_COLLECT;
         r_byte_cnt  <= 4'd0;
         r_idle_cnt  <= '0;
         r_shift     <= '0;
         r_type      <= 1'b0;
         r_pend      <= '0;
         r_pend_key  <= 1'b0;
         r_pt        <= '0;
         r_key       <= '0;
         r_key_valid <= 1'b0;
         r_start     <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_start     <= w_commit && !w_commit_key;
         r_frame_err <= w_drop || w_timeout;
         if (w_accept) begin
            r_shift    <= w_value[119:0];
            r_byte_cnt <= w_last ? 4'd0 : r_byte_cnt + 4'd1;
            r_idle_cnt <= '0;
            if (r_byte_cnt == 4'd0) r_type <= key_sel;
         end else if (w_timeout) begin
            r_shift    <= '0;
            r_byte_cnt <= 4'd0;
            r_idle_cnt <= '0;
         end else if (w_idle_run) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
         end
         if (w_park) begin
            r_pend     <= w_value;
            r_pend_key <= w_type;
         end
         if (w_commit) begin
            if (w_commit_key) begin
               r_key       <= w_commit_val;
               r_key_valid <= 1'b1;
            end else begin
               r_pt <= w_commit_val;
            end
         end
      end
   end

   assign in_ready  = (r_state == S_COLLECT);
   assign plaintext = r_pt;
   assign key       = r_key;
   assign key_valid = r_key_valid;
   assign start     = r_start;
   assign frame_err = r_frame_err;

endmodule
